// File: rtl/stack_alu_ctrl.sv
// -----------------------------------------------------------------------------
// stack_alu_ctrl
//
// This block drives an external combinational ALU from a small operand stack.
// It takes one command at a time through a valid/ready handshake:
//   PUSH  - pushes cmd_data onto the stack.
//   POP   - removes the top entry and returns it.
//   BINOP - sends top and second to the ALU, pops both, and pushes the result.
//   UNOP  - sends top to the ALU and replaces top with the result.
// PUSH, POP and every rejected command finish in IDLE. BINOP and UNOP go
// through IDLE -> EXEC -> WB.
//
// Optional feature: when STACK_ALU_CTRL_FCHK_EN is defined, the block rejects
// any BINOP or UNOP whose cmd_f lies outside that operation's code class.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (cmd_ready is high only in IDLE)
//   cmd_op            00 PUSH, 01 BINOP, 10 UNOP, 11 POP
//   cmd_f             ALU function code for BINOP/UNOP
//   cmd_data          PUSH operand
//   alu_a/alu_b/alu_f ALU operands and function; these are 0 outside EXEC
//   alu_s             combinational ALU result
//   rsp_valid         one-cycle completion pulse
//   rsp_data          new top of stack, or the popped value; 0 on reject
//   rsp_err           marks the response as a rejected command
//   depth             current stack occupancy
// -----------------------------------------------------------------------------
module stack_alu_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_f,
    input  logic [15:0] cmd_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    input  logic [15:0] alu_s,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [3:0]  depth
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_BINOP = 2'b01,
        OP_UNOP  = 2'b10,
        OP_POP   = 2'b11
    } op_t;

    state_t        state;
    logic          is_bin;
    logic [15:0]   stack [DEPTH];

    logic [AW-1:0] top_idx;
    logic [AW-1:0] sec_idx;
    logic [AW-1:0] push_idx;
    op_t           op;
    logic          accept;
    logic          f_ok_bin;
    logic          f_ok_un;
    logic          reject;

    // Only the low bits of depth are used as an index. Whenever an index is
    // actually used, depth is within range.
    assign top_idx  = AW'(depth - 4'd1);
    assign sec_idx  = AW'(depth - 4'd2);
    assign push_idx = AW'(depth);
    assign op       = op_t'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;

`ifdef STACK_ALU_CTRL_FCHK_EN
    assign f_ok_bin = (cmd_f <= 5'b01111);
    assign f_ok_un  = (cmd_f >= 5'b10000) && (cmd_f <= 5'b10010);
`else
    assign f_ok_bin = 1'b1;
    assign f_ok_un  = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        reject = 1'b0;
        case (op)
            OP_PUSH:  reject = (depth == DEPTH_MAX);
            OP_POP:   reject = (depth == 4'd0);
            OP_UNOP:  reject = (depth == 4'd0) || !f_ok_un;
            OP_BINOP: reject = (depth < 4'd2) || !f_ok_bin;
            default:  reject = 1'b0;
        endcase
    end

    // Stack write port. The block writes the stack in two places: on an
    // accepted PUSH in IDLE, and at the end of EXEC with the ALU result.
    logic          stk_we;
    logic [AW-1:0] stk_widx;
    logic [15:0]   stk_wdata;

    always_comb begin
        stk_we    = 1'b0;
        stk_widx  = push_idx;
        stk_wdata = cmd_data;
        if (state == EXEC) begin
            stk_we    = 1'b1;
            stk_widx  = is_bin ? sec_idx : top_idx;
            stk_wdata = alu_s;
        end else if (state == IDLE && accept && op == OP_PUSH && !reject) begin
            stk_we = 1'b1;
        end
    end

    // NOTE: the stack storage has no reset. depth alone decides which entries are live.
    // Gating the write with rst keeps an edge that arrives during reset from
    // changing the contents.
    always_ff @(posedge clk) begin
        if (stk_we && !rst) begin
            stack[stk_widx] <= stk_wdata;
        end
    end

    // NOTE: sequential state uses only non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_bin    <= 1'b0;
            cmd_ready <= 1'b1;
            depth     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 16'd0;
            alu_a     <= 16'd0;
            alu_b     <= 16'd0;
            alu_f     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= 16'd0;
                    if (accept) begin
                        if (reject) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            case (op)
                                OP_PUSH: begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= cmd_data;
                                    depth     <= depth + 4'd1;
                                end
                                OP_POP: begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= stack[top_idx];
                                    depth     <= depth - 4'd1;
                                end
                                OP_BINOP: begin
                                    state     <= EXEC;
                                    cmd_ready <= 1'b0;
                                    is_bin    <= 1'b1;
                                    alu_a     <= stack[top_idx];
                                    alu_b     <= stack[sec_idx];
                                    alu_f     <= cmd_f;
                                end
                                default: begin // OP_UNOP
                                    state     <= EXEC;
                                    cmd_ready <= 1'b0;
                                    is_bin    <= 1'b0;
                                    alu_a     <= stack[top_idx];
                                    alu_b     <= 16'd0;
                                    alu_f     <= cmd_f;
                                end
                            endcase
                        end
                    end
                end
                EXEC: begin
                    // Capture the ALU result. The stack write at this edge
                    // completes the command, and the response appears in WB.
                    alu_a     <= 16'd0;
                    alu_b     <= 16'd0;
                    alu_f     <= 5'd0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_s;
                    if (is_bin) begin
                        depth <= depth - 4'd1;
                    end
                    state <= WB;
                end
                WB: begin
                    rsp_valid <= 1'b0;
                    rsp_data  <= 16'd0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/stack_alu_ctrl.md
STACK_ALU_CTRL -- requirements
Module: stack_alu_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, operand-stack entries (legal 2..15).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  controller can accept a command.
REQ-006 cmd_op  in  2  00 PUSH, 01 BINOP, 10 UNOP, 11 POP.
REQ-007 cmd_f  in  5  ALU function code for BINOP/UNOP (ALU encoding 00000..10010).
REQ-008 cmd_data  in  16  PUSH operand.
REQ-009 alu_a  out  16  ALU a operand (top of stack).
REQ-010 alu_b  out  16  ALU b operand (second entry).
REQ-011 alu_f  out  5  ALU function code.
REQ-012 alu_s  in  16  combinational ALU result.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_data  out  16  new top of stack (PUSH/BINOP/UNOP) or popped value (POP).
REQ-015 rsp_err  out  1  qualifies rsp_valid: command rejected.
REQ-016 depth  out  4  current stack occupancy.

Function
REQ-017 States IDLE, EXEC, WB; cmd_ready SHALL be 1 only in IDLE.
REQ-018 Command SHALL be accepted on a clk edge with cmd_valid && cmd_ready; cmd_* sampled only then, ignored otherwise.
REQ-019 PUSH/POP and any rejected command SHALL complete in IDLE: rsp_valid high in cycle T+1 after acceptance edge T, state stays IDLE.
REQ-020 BINOP/UNOP accepted SHALL go IDLE->EXEC; in EXEC alu_a=stack[top], alu_b=stack[top-1] (UNOP: alu_b=0), alu_f=latched cmd_f; alu_s captured at end of EXEC.
REQ-021 EXEC->WB->IDLE unconditionally; in WB rsp_valid=1, rsp_data=result; total latency acceptance to rsp_valid = 2 cycles.
REQ-022 BINOP SHALL pop two, push result (depth-1); UNOP SHALL replace top (depth unchanged).
REQ-023 Operand order: result = second OP top (SUB: second - top).
REQ-024 Outside EXEC alu_a, alu_b = 0, alu_f = 00000.
REQ-025 Reject (rsp_err=1, stack and depth unchanged): PUSH at depth==DEPTH; POP/UNOP at depth 0; BINOP at depth<2.
REQ-026 rsp_data SHALL be 0 when rsp_err=1 or rsp_valid=0.
REQ-027 depth SHALL never wrap; results wider than 16 bits truncated by ALU, not checked.

Reset
REQ-028 rst SHALL asynchronously force state IDLE, depth 0, rsp_valid 0, rsp_err 0, rsp_data 0, alu_* 0; stack storage not reset.
REQ-029 rst during EXEC or WB SHALL abort the command: no rsp_valid, no stack update.
REQ-030 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro STACK_ALU_CTRL_FCHK_EN defined: BINOP with cmd_f outside 00000..01111, UNOP with cmd_f outside 10000..10010, SHALL be rejected per REQ-025.
REQ-032 Macro undefined: cmd_f SHALL pass unchecked; out-of-class codes execute, result is whatever alu_s returns.

Verification
REQ-033 PUSH 0x0005, PUSH 0x0003, BINOP f=00001 -> rsp_valid 2 cycles after accept, rsp_data 0x0002, rsp_err 0, depth 1.
REQ-034 9 PUSH 0x0007 at DEPTH=8 -> 9th response rsp_err 1, depth stays 8; following POP returns 0x0007, depth 7.
REQ-035 PUSH 0x0001, BINOP f=00000 -> rsp_err 1, depth 1; UNOP f=10000 -> rsp_data 0xFFFF, depth 1.
REQ-036 PUSH 0x0004, PUSH 0x0002, BINOP f=00000 with rst pulsed during EXEC -> no rsp_valid, depth 0, cmd_ready 1 cycle after release.
REQ-037 cmd_valid held high during EXEC with PUSH 0x00AA -> not accepted until IDLE; accepted once, depth increments by exactly 1.
REQ-038 PUSH 0x0002, PUSH 0x0001, BINOP f=10001 -> STACK_ALU_CTRL_FCHK_EN defined: rsp_err 1, depth 2; undefined: rsp_err 0, depth 1, rsp_data 0xFFFE.
